// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU writeback (A) always wins, long-latency
// completions (B) queue in a small FIFO. Optional same-cycle B bypass: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_en,
  input  logic        a_wen,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_wdata,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        wb_wen,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_wdata,
  output logic        stall_req
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(STARVE_MAX + 1);

  logic [4:0]       q_rd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WW-1:0]    wait_cnt, wait_next;
  logic             stall_q;

  logic full, empty, a_active, deq, bypass, accept, push;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign a_active = !rst && a_wen && (a_rd != 5'd0) && pipeline_en;
  assign deq      = !rst && pipeline_en && !a_active && !empty;

`ifdef RF_WB_BYPASS_EN
  assign bypass = !rst && empty && pipeline_en && !a_active && b_valid && (b_rd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Valid/ready: a B completion transfers in any cycle where b_valid && b_ready
  // at the rising edge; b_ready never depends on a same-cycle pop.
  assign b_ready = !full && !rst;
  assign accept  = b_valid && b_ready;
  assign push    = accept && (b_rd != 5'd0) && !bypass;

  always_comb begin
    wb_wen   = 1'b0;
    wb_rd    = 5'd0;
    wb_wdata = 32'd0;
    if (a_active) begin
      wb_wen   = 1'b1;
      wb_rd    = a_rd;
      wb_wdata = a_wdata;
    end else if (deq) begin
      wb_wen   = 1'b1;
      wb_rd    = q_rd[rd_ptr];
      wb_wdata = q_data[rd_ptr];
    end else if (bypass) begin
      wb_wen   = 1'b1;
      wb_rd    = b_rd;
      wb_wdata = b_wdata;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && (((rs1 != 5'd0) && (q_rd[i] == rs1)) ||
                         ((rs2 != 5'd0) && (q_rd[i] == rs2))))
        hazard = 1'b1;
    end
    if (rst) hazard = 1'b0;
  end

  // Counts cycles the head sits undequeued; saturates so stall_req holds steady.
  always_comb begin
    wait_next = wait_cnt;
    if (empty || deq)
      wait_next = '0;
    else if (wait_cnt != WW'(STARVE_MAX))
      wait_next = wait_cnt + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      q_valid  <= '0;
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (push) begin
        q_rd[wr_ptr]    <= b_rd;
        q_data[wr_ptr]  <= b_wdata;
        q_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (deq) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      count    <= count + CW'(push) - CW'(deq);
      wait_cnt <= wait_next;
      stall_q  <= (wait_next == WW'(STARVE_MAX));
    end
  end

  assign stall_req = stall_q && !rst;

endmodule
